bus_move_sequencer: RTL and testbench
=====================================

Name: bus_move_sequencer

Overview:
- Control stage directly upstream of the 16-bit tri-state general-purpose registers on the shared data bus.
- Accepts one register-transfer command at a time: MOV, SWAP, load-immediate (LDI) or NOP.
- Sequences the per-register read/write enables cycle by cycle, and sources the bus itself for immediates and the SWAP temporary.
- Guarantees at most one bus driver in any cycle.

Parameters:
- NREGS, 8, number of registers addressed; one read and one write enable each.
- IDX_W, 3, width of the src/dst index; clog2(NREGS).
- DATA_W, 16, bus and immediate width.

Ports:
- clk  in  1  rising-edge clock shared with the registers.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  2  command code: 0 MOV, 1 SWAP, 2 LDI, 3 NOP.
- src  in  IDX_W  source register index.
- dst  in  IDX_W  destination register index.
- imm  in  DATA_W  immediate value for LDI.
- bus_in  in  DATA_W  resolved bus value; captured into the temporary.
- reg_read  out  NREGS  one-hot register output enables.
- reg_write  out  NREGS  one-hot register write enables.
- bus_out  out  DATA_W  value this block drives onto the bus.
- bus_oe  out  1  enable for bus_out onto the bus.
- busy  out  1  a command is executing.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state = IDLE; temp = 0; latched operands = 0.
  - All outputs 0: reg_read, reg_write, bus_oe, bus_out, busy, done.
  - Reset mid-command abandons it; no further enables are asserted.
- States: IDLE, MOV, LDI, SW1, SW2, SW3, NOP.
- IDLE:
  - All enables 0.
  - On the posedge with start=1: latch op/src/dst/imm, go to MOV, SWAP→SW1, LDI or NOP per op.
  - start while busy is ignored; it is not queued.
- MOV, one cycle:
  - reg_read[src]=1, reg_write[dst]=1; dst captures src at the closing edge.
  - src==dst is legal; register unchanged.
- LDI, one cycle: bus_oe=1, bus_out=imm, reg_write[dst]=1.
- SWAP, three cycles:
  - SW1: reg_read[src]=1; temp <= bus_in at the edge.
  - SW2: reg_read[dst]=1, reg_write[src]=1.
  - SW3: bus_oe=1, bus_out=temp, reg_write[dst]=1.
  - src==dst executes all three cycles; value unchanged.
- NOP, one cycle: no enables.
- After every execution state return to IDLE.
- busy = 1 in every execution state (combinational from state).
- done: registered, 1 for exactly the one IDLE cycle after the last execution cycle.
- Back-to-back commands:
  - start may be high in the done cycle; it is accepted then.
  - Minimum command spacing: MOV/LDI/NOP = 2 cycles, SWAP = 4 cycles.
- Enables are decoded from registered state and latched indices only, so they are glitch-free with respect to input changes mid-command.
- Invariants, checked by assertion:
  - popcount(reg_read) + bus_oe <= 1.
  - popcount(reg_write) <= 1.
  - bus_oe=0 implies bus_out=0.
- Index >= NREGS (only possible when NREGS < 2^IDX_W): the corresponding enable is all-zero and the command still completes with done.

Test Plan:
1. Reset, then R2=0x1234; MOV src=2 dst=5 → one cycle with reg_read=0x04, reg_write=0x20; R5=0x1234; done pulses next cycle.
2. LDI imm=0xBEEF dst=0 → bus_oe=1, bus_out=0xBEEF, reg_write=0x01 for one cycle; R0=0xBEEF; bus_out returns to 0.
3. R1=0xAAAA, R3=0x5555; SWAP src=1 dst=3 → busy for 3 cycles: reg_read=0x02; then reg_read=0x08/reg_write=0x02; then bus_oe with bus_out=0xAAAA/reg_write=0x08. Result R1=0x5555, R3=0xAAAA.
4. start pulsed in SW2 with op=MOV → ignored: no extra enables, a single done. Then start in the done cycle → accepted; MOV executes next cycle.
5. rst_n low during SW2 → all enables 0 immediately; after release state is IDLE, temp=0, no done pulse.
6. Random 1000-command stream against a register-file model → register contents match the model; bus-driver invariants hold every cycle.

Source files
------------

// File: rtl/bus_move_sequencer.sv
// Register-transfer sequencer for the shared 16-bit data bus.
// Walks MOV / SWAP / LDI / NOP through one-hot read/write enables and owns the bus for immediates and the swap temporary.
module bus_move_sequencer #(
  parameter int NREGS  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [IDX_W-1:0]  src,
  input  logic [IDX_W-1:0]  dst,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] bus_in,
  output logic [NREGS-1:0]  reg_read,
  output logic [NREGS-1:0]  reg_write,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOV, S_LDI, S_SW1, S_SW2, S_SW3, S_NOP
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  src_q, dst_q;
  logic [DATA_W-1:0] imm_q, temp;

  // Out-of-range indices decode to no enable at all.
  function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NREGS; i++)
      if (int'(idx) == i) onehot[i] = 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
      temp  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          src_q <= src;
          dst_q <= dst;
          imm_q <= imm;
          case (op)
            2'd0:    state <= S_MOV;
            2'd1:    state <= S_SW1;
            2'd2:    state <= S_LDI;
            default: state <= S_NOP;
          endcase
        end
        S_SW1: begin
          temp  <= bus_in;
          state <= S_SW2;
        end
        S_SW2: state <= S_SW3;
        default: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

  // Enables depend only on registered state and latched operands.
  always_comb begin
    reg_read  = '0;
    reg_write = '0;
    bus_oe    = 1'b0;
    bus_out   = '0;
    case (state)
      S_MOV: begin
        reg_read  = onehot(src_q);
        reg_write = onehot(dst_q);
      end
      S_LDI: begin
        bus_oe    = 1'b1;
        bus_out   = imm_q;
        reg_write = onehot(dst_q);
      end
      S_SW1: reg_read = onehot(src_q);
      S_SW2: begin
        reg_read  = onehot(dst_q);
        reg_write = onehot(src_q);
      end
      S_SW3: begin
        bus_oe    = 1'b1;
        bus_out   = temp;
        reg_write = onehot(dst_q);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always @(posedge clk) begin
    if (rst_n) begin
      assert (int'($countones(reg_read)) + int'(bus_oe) <= 1);
      assert ($countones(reg_write) <= 1);
      assert (bus_oe || bus_out == '0);
    end
  end

endmodule

// File: tb/tb_bus_move_sequencer.sv
// Bench for bus_move_sequencer: a tri-state register file built around the DUT,
// checked against a command-level register model.
module tb_bus_move_sequencer;
  localparam int NREGS = 8, IDX_W = 3, DATA_W = 16;

  logic              clk = 0, rst_n = 0, start = 0;
  logic [1:0]        op = '0;
  logic [IDX_W-1:0]  src = '0, dst = '0;
  logic [DATA_W-1:0] imm = '0;
  logic [DATA_W-1:0] bus_in, bus_out;
  logic [NREGS-1:0]  reg_read, reg_write;
  logic              bus_oe, busy, done;

  logic [DATA_W-1:0] rf   [NREGS] = '{default: '0};
  logic [DATA_W-1:0] gold [NREGS] = '{default: '0};
  int checks = 0, failures = 0;
  bit inv_en = 0;

  bus_move_sequencer #(.NREGS(NREGS), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .imm(imm), .bus_in(bus_in), .reg_read(reg_read), .reg_write(reg_write),
    .bus_out(bus_out), .bus_oe(bus_oe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Resolved bus: whoever is enabled drives it.
  always_comb begin
    bus_in = bus_oe ? bus_out : '0;
    for (int i = 0; i < NREGS; i++)
      if (reg_read[i]) bus_in = bus_in | rf[i];
  end

  always @(posedge clk)
    for (int i = 0; i < NREGS; i++)
      if (reg_write[i]) rf[i] <= bus_in;

  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ($countones(reg_read) + int'(bus_oe) > 1 || $countones(reg_write) > 1 ||
          (!bus_oe && bus_out !== '0)) begin
        failures++;
        $display("FAIL bus_invariant rd=%h wr=%h oe=%b out=%h", reg_read, reg_write, bus_oe, bus_out);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic send(input logic [1:0] o, input int s, input int d, input logic [DATA_W-1:0] v, input bit upd);
    logic [DATA_W-1:0] t;
    start = 1; op = o; src = s[IDX_W-1:0]; dst = d[IDX_W-1:0]; imm = v;
    @(posedge clk); #1;
    start = 0; op = 2'($urandom); src = IDX_W'($urandom); dst = IDX_W'($urandom); imm = DATA_W'($urandom);
    if (upd) begin
      case (o)
        2'd0: gold[d] = gold[s];
        2'd1: begin t = gold[s]; gold[s] = gold[d]; gold[d] = t; end
        2'd2: gold[d] = v;
        default: ;
      endcase
    end
  endtask

  task automatic finish_cmd(output int nbusy, output bit seen);
    nbusy = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({reg_read, reg_write, bus_oe, bus_out, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rd=%h wr=%h oe=%b out=%h busy=%b done=%b exp all 0",
               reg_read, reg_write, bus_oe, bus_out, busy, done);
    end
    @(posedge clk); #1 rst_n = 1;
    inv_en = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0) begin
      failures++; $display("FAIL reset_idle busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_mov;
    int nb; bit seen;
    send(2, 0, 2, 16'h1234, 1); finish_cmd(nb, seen);
    send(0, 2, 5, 16'h0, 1);
    @(negedge clk);
    checks++;
    if (reg_read !== 8'h04 || reg_write !== 8'h20 || bus_oe !== 0 || busy !== 1 || done !== 0) begin
      failures++; $display("FAIL mov_enables rd=%h wr=%h oe=%b busy=%b exp 04 20 0 1", reg_read, reg_write, bus_oe, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1 || busy !== 0 || reg_read !== 0 || reg_write !== 0) begin
      failures++; $display("FAIL mov_done done=%b busy=%b rd=%h wr=%h exp 1 0 0 0", done, busy, reg_read, reg_write);
    end
    checks++;
    if (rf[5] !== 16'h1234) begin failures++; $display("FAIL mov_result R5=%h exp 1234", rf[5]); end
    @(negedge clk);
    checks++;
    if (done !== 0) begin failures++; $display("FAIL mov_done_width done=%b exp 0", done); end
  endtask

  task automatic test_ldi;
    send(2, 0, 0, 16'hBEEF, 1);
    @(negedge clk);
    checks++;
    if (bus_oe !== 1 || bus_out !== 16'hBEEF || reg_write !== 8'h01 || reg_read !== 0) begin
      failures++; $display("FAIL ldi_drive oe=%b out=%h wr=%h rd=%h exp 1 beef 01 00", bus_oe, bus_out, reg_write, reg_read);
    end
    @(negedge clk);
    checks++;
    if (bus_oe !== 0 || bus_out !== 0 || done !== 1 || rf[0] !== 16'hBEEF) begin
      failures++; $display("FAIL ldi_after oe=%b out=%h done=%b R0=%h exp 0 0 1 beef", bus_oe, bus_out, done, rf[0]);
    end
  endtask

  task automatic test_swap;
    int nb; bit seen;
    send(2, 0, 1, 16'hAAAA, 1); finish_cmd(nb, seen);
    send(2, 0, 3, 16'h5555, 1); finish_cmd(nb, seen);
    send(1, 1, 3, 16'h0, 1);
    @(negedge clk);
    checks++;
    if (reg_read !== 8'h02 || reg_write !== 0 || bus_oe !== 0 || busy !== 1) begin
      failures++; $display("FAIL swap_sw1 rd=%h wr=%h oe=%b exp 02 00 0", reg_read, reg_write, bus_oe);
    end
    @(negedge clk);
    checks++;
    if (reg_read !== 8'h08 || reg_write !== 8'h02 || bus_oe !== 0 || busy !== 1) begin
      failures++; $display("FAIL swap_sw2 rd=%h wr=%h oe=%b exp 08 02 0", reg_read, reg_write, bus_oe);
    end
    @(negedge clk);
    checks++;
    if (bus_oe !== 1 || bus_out !== 16'hAAAA || reg_write !== 8'h08 || reg_read !== 0 || busy !== 1) begin
      failures++; $display("FAIL swap_sw3 oe=%b out=%h wr=%h rd=%h exp 1 aaaa 08 00", bus_oe, bus_out, reg_write, reg_read);
    end
    @(negedge clk);
    checks++;
    if (done !== 1 || rf[1] !== 16'h5555 || rf[3] !== 16'hAAAA) begin
      failures++; $display("FAIL swap_result done=%b R1=%h R3=%h exp 1 5555 aaaa", done, rf[1], rf[3]);
    end
  endtask

  task automatic test_back_to_back;
    send(1, 1, 3, 16'h0, 1);
    @(negedge clk);
    @(posedge clk); #1;
    start = 1; op = 2'd0; src = 3'd0; dst = 3'd7;
    @(negedge clk);
    checks++;
    if (reg_read !== 8'h08 || reg_write !== 8'h02) begin
      failures++; $display("FAIL b2b_sw2 rd=%h wr=%h exp 08 02", reg_read, reg_write);
    end
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    checks++;
    if (bus_oe !== 1 || bus_out !== gold[3] || reg_write !== 8'h08) begin
      failures++; $display("FAIL b2b_sw3 oe=%b out=%h wr=%h exp 1 %h 08", bus_oe, bus_out, reg_write, gold[3]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1 || busy !== 0 || reg_read !== 0 || reg_write !== 0) begin
      failures++; $display("FAIL b2b_ignored done=%b busy=%b rd=%h wr=%h exp 1 0 0 0", done, busy, reg_read, reg_write);
    end
    send(0, 3, 6, 16'h0, 1);
    @(negedge clk);
    checks++;
    if (reg_read !== 8'h08 || reg_write !== 8'h40 || done !== 0) begin
      failures++; $display("FAIL b2b_accept rd=%h wr=%h done=%b exp 08 40 0", reg_read, reg_write, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1 || rf[6] !== gold[6] || rf[7] !== gold[7]) begin
      failures++; $display("FAIL b2b_result done=%b R6=%h exp %h R7=%h exp %h", done, rf[6], gold[6], rf[7], gold[7]);
    end
  endtask

  task automatic test_reset_mid;
    int nb; bit seen;
    send(2, 0, 4, 16'h4444, 1); finish_cmd(nb, seen);
    send(2, 0, 5, 16'h5A5A, 1); finish_cmd(nb, seen);
    send(1, 4, 5, 16'h0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (reg_read !== 8'h20 || reg_write !== 8'h10) begin
      failures++; $display("FAIL rstmid_sw2 rd=%h wr=%h exp 20 10", reg_read, reg_write);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({reg_read, reg_write, bus_oe, bus_out, busy, done} !== '0 || dut.temp !== '0) begin
      failures++; $display("FAIL rstmid_clear rd=%h wr=%h oe=%b busy=%b temp=%h exp all 0",
                           reg_read, reg_write, bus_oe, busy, dut.temp);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 0 || busy !== 0 || reg_write !== 0) begin
        failures++; $display("FAIL rstmid_quiet cyc=%0d done=%b busy=%b wr=%h exp 0 0 0", k, done, busy, reg_write);
      end
    end
    checks++;
    if (rf[4] !== gold[4] || rf[5] !== gold[5]) begin
      failures++; $display("FAIL rstmid_regs R4=%h exp %h R5=%h exp %h", rf[4], gold[4], rf[5], gold[5]);
    end
  endtask

  task automatic test_random;
    int nb, exp_nb, s, d; bit seen;
    logic [1:0] o;
    for (int i = 0; i < NREGS; i++) begin
      send(2, 0, i, DATA_W'($urandom), 1); finish_cmd(nb, seen);
    end
    for (int n = 0; n < 1000; n++) begin
      o = 2'($urandom); s = $urandom_range(0, NREGS-1); d = $urandom_range(0, NREGS-1);
      send(o, s, d, DATA_W'($urandom), 1);
      finish_cmd(nb, seen);
      exp_nb = (o == 2'd1) ? 3 : 1;
      checks++;
      if (!seen || nb != exp_nb) begin
        failures++; $display("FAIL rand_latency cmd=%0d op=%0d seen_done=%b busy_cycles=%0d exp %0d", n, o, seen, nb, exp_nb);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
    for (int i = 0; i < NREGS; i++) begin
      checks++;
      if (rf[i] !== gold[i]) begin
        failures++; $display("FAIL rand_regfile R%0d=%h exp %h", i, rf[i], gold[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mov;
    test_ldi;
    test_swap;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
